// File: rtl/round_pkg.sv
// Shared encodings for the FP significand-rounding sequencer.
// State codes are 3-bit; rounding-mode codes match the round_type_i field.
package round_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECIDE = 3'd1;
    localparam logic [2:0] ST_INCR   = 3'd2;
    localparam logic [2:0] ST_NORM   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DECIDE = ST_DECIDE,
        INCR   = ST_INCR,
        NORM   = ST_NORM,
        DONE   = ST_DONE
    } state_t;

    localparam logic [1:0] RND_ZERO = 2'b00;
    localparam logic [1:0] RND_NEG  = 2'b01;
    localparam logic [1:0] RND_POS  = 2'b10;
    localparam logic [1:0] RND_NEAR = 2'b11;

endpackage

// File: rtl/round_sgf_ctrl_round_up_decide.sv
// Combinational round-up decision from sign, mode, guard, sticky and LSB.
// Macro ROUND_NEAREST_EN turns mode 11 into round-to-nearest-even; otherwise it truncates.
module round_up_decide
    import round_pkg::*;
(
    input  logic       sign,
    input  logic [1:0] rnd_type,
    input  logic       guard,
    input  logic       sticky,
    input  logic       lsb,
    output logic       round_up
);

`ifdef ROUND_NEAREST_EN
    localparam bit NEAR_EN = 1'b1;
`else
    localparam bit NEAR_EN = 1'b0;
`endif

    always_comb begin
        round_up = 1'b0;
        unique case (rnd_type)
            RND_NEG:  round_up = (guard | sticky) & sign;
            RND_POS:  round_up = (guard | sticky) & ~sign;
            // Ties (G=1, S=0) round up only when that makes the LSB even.
            RND_NEAR: round_up = NEAR_EN & guard & (sticky | lsb);
            default:  round_up = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_sgf_ctrl.sv
// Multi-cycle significand rounding sequencer with start/ready/done handshake.
// Optional round-to-nearest-even for mode 11 under macro ROUND_NEAREST_EN.
module round_sgf_ctrl
    import round_pkg::*;
#(
    parameter int SWD = 24,
    parameter int EW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWD+1:0] sgf_i,
    input  logic [EW-1:0]  exp_i,
    input  logic           sign_i,
    input  logic [1:0]     round_type_i,
    output logic           ready_o,
    output logic           done_o,
    output logic [SWD-1:0] sgf_o,
    output logic [EW-1:0]  exp_o,
    output logic           inexact_o,
    output logic           overflow_o
);

    localparam logic [EW-1:0] EXP_MAX = '1;

    state_t         state_q, state_d;
    logic [SWD-1:0] sgf_q, sgf_d;
    logic [1:0]     gs_q, gs_d;
    logic [EW-1:0]  exp_q, exp_d;
    logic           sign_q, sign_d;
    logic [1:0]     type_q, type_d;
    logic           inexact_q, inexact_d;
    logic           ovf_q, ovf_d;

    logic           round_up;
    logic [SWD:0]   incr;
    logic [EW-1:0]  exp_inc;

    assign incr    = {1'b0, sgf_q} + {{SWD{1'b0}}, 1'b1};
    assign exp_inc = exp_q + {{(EW-1){1'b0}}, 1'b1};

    round_up_decide u_decide (
        .sign     (sign_q),
        .rnd_type (type_q),
        .guard    (gs_q[1]),
        .sticky   (gs_q[0]),
        .lsb      (sgf_q[0]),
        .round_up (round_up)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sgf_d     = sgf_q;
        gs_d      = gs_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        type_d    = type_q;
        inexact_d = inexact_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sgf_d     = sgf_i[SWD+1:2];
                    gs_d      = sgf_i[1:0];
                    exp_d     = exp_i;
                    sign_d    = sign_i;
                    type_d    = round_type_i;
                    inexact_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = DECIDE;
                end
            end
            DECIDE: begin
                inexact_d = |gs_q;
                state_d   = round_up ? INCR : DONE;
            end
            INCR: begin
                if (incr[SWD]) begin
                    state_d = NORM;
                end else begin
                    sgf_d   = incr[SWD-1:0];
                    state_d = DONE;
                end
            end
            NORM: begin
                sgf_d = {1'b1, {(SWD-1){1'b0}}};
                // A saturated exponent stays put rather than wrapping to zero.
                if (exp_q == EXP_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    exp_d = exp_inc;
                    ovf_d = (exp_inc == EXP_MAX);
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sgf_q      <= '0;
            gs_q       <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            type_q     <= RND_ZERO;
            inexact_q  <= 1'b0;
            ovf_q      <= 1'b0;
            sgf_o      <= '0;
            exp_o      <= '0;
            inexact_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            sgf_q     <= sgf_d;
            gs_q      <= gs_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            type_q    <= type_d;
            inexact_q <= inexact_d;
            ovf_q     <= ovf_d;
            // Visible results change only on entry to DONE and hold until the next one.
            if (state_d == DONE) begin
                sgf_o      <= sgf_d;
                exp_o      <= exp_d;
                inexact_o  <= inexact_d;
                overflow_o <= ovf_d;
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign done_o  = (state_q == DONE);

endmodule

// File: doc/round_sgf_ctrl.md
Name: round_sgf_ctrl

Overview:
- Multi-cycle sequencer for the significand-rounding stage of the FP add/subtract unit.
- Captures a normalized significand with its guard and sticky bits, exponent, sign and rounding mode, then decides whether to round.
- On round-up it increments the significand, renormalizes on carry-out, bumps the exponent and flags overflow/inexact.
- Sits between the normalization shifter and final result packing; uses a start/ready/done handshake.

Parameters:
SWD, 24, significand width including hidden bit (single precision)
EW, 8, exponent width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start_i  in  1  request pulse; accepted only when ready_o=1
sgf_i  in  SWD+2  {significand[SWD-1:0], guard, sticky}
exp_i  in  EW  biased exponent of normalized operand
sign_i  in  1  result sign
round_type_i  in  2  00 toward zero, 01 toward -inf, 10 toward +inf, 11 see Optional Feature
ready_o  out  1  high in IDLE
done_o  out  1  one-cycle pulse when result valid
sgf_o  out  SWD  rounded significand
exp_o  out  EW  adjusted exponent
inexact_o  out  1  guard|sticky nonzero
overflow_o  out  1  exponent reached all-ones through rounding

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ready_o=1; done_o=0; sgf_o, exp_o, inexact_o, overflow_o = 0.
- States: IDLE, DECIDE, INCR, NORM, DONE.
- IDLE: on start_i=1, register all inputs; go to DECIDE. ready_o=0 in every state except IDLE.
- DECIDE: compute round_up = |GS & ((type=01 & sign=1) | (type=10 & sign=0)); types 00 and 11 never round up (11 changes with the Optional Feature). inexact = |GS.
  - round_up → INCR; otherwise → DONE.
- INCR: {carry, sum} = {1'b0, sgf} + 1 (SWD+1-bit add).
  - carry=1 → NORM; otherwise → DONE with sgf=sum.
- NORM: sgf = {1'b1, {SWD-1{1'b0}}}; exp = exp+1.
  - If exp+1 == 2^EW-1: overflow=1, exp held at all-ones.
  - Exponent input already all-ones: overflow=1, exp unchanged (no wrap).
  - → DONE.
- DONE: outputs registered and valid; done_o=1 for exactly this cycle; → IDLE.
- Outputs hold their values until the next DONE; they are updated only on entry to DONE.
- Latency from start (cycle 0) to done_o: no round 2 cycles; round without carry 3; round with carry 4.
- start_i while ready_o=0 is ignored; no queuing.
- Reset mid-operation aborts the operation and produces no done_o.
- GS=00 never rounds and never sets inexact, in any mode.

Optional Feature:
- Macro: ROUND_NEAREST_EN.
- Defined: round_type 11 = round-to-nearest-even; round_up = G & (S | sgf[0]), sign-independent; the rest of the flow is unchanged.
- Undefined: type 11 truncates (identical to 00).

Decomposition:
- Package round_pkg:
  - state encoding localparams (IDLE..DONE, 3-bit);
  - round-mode codes RND_ZERO=2'b00, RND_NEG=2'b01, RND_POS=2'b10, RND_NEAR=2'b11.
- One sub-module, round_up_decide: combinational {sign, type, G, S, lsb} → round_up. It carries the ROUND_NEAREST_EN branch.
- The FSM and datapath registers stay in round_sgf_ctrl.

Test Plan:
- type=10, sign=0, sgf=0x000001, GS=01, exp=0x80 → done at cycle 3; sgf_o=0x000002, exp_o=0x80, inexact_o=1, overflow_o=0.
- type=01, sign=0, sgf=0x123456, GS=11 → done at cycle 2; sgf_o=0x123456, inexact_o=1. Repeat with sign=1 → sgf_o=0x123457, done at cycle 3.
- type=10, sign=0, sgf=0xFFFFFF, GS=10, exp=0x80 → done at cycle 4; sgf_o=0x800000, exp_o=0x81, overflow_o=0. Repeat with exp=0xFE → exp_o=0xFF, overflow_o=1.
- type=00, any sign, GS=11 → no round, done at cycle 2. GS=00 in all modes → inexact_o=0, sgf unchanged.
- Assert rst=0 while in INCR → ready_o=1 and all outputs 0 immediately, no done_o. start_i pulsed in DECIDE → ignored; only one done_o produced.
- With ROUND_NEAREST_EN: type=11, sgf=0x000003, GS=10 → 0x000004. Same input with sgf=0x000002 → 0x000002 (tie to even). Without the macro → 0x000003 unchanged.
